// File: rtl/gpio_port.sv
// Memory-mapped GPIO responder: per-bit direction, atomic set/clear, two-flop
// input synchroniser and rising-edge capture with a maskable level interrupt.
module gpio_port #(
   parameter int unsigned WIDTH     = 32,
   parameter logic [31:0] OUT_RESET = 32'h0,
   parameter logic [31:0] DIR_RESET = 32'h0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clk_en,
   input  logic             i_sel,
   input  logic             i_wr,
   input  logic             i_rd,
   input  logic [2:0]       i_addr,
   input  logic [31:0]      i_wdata,
   output logic [31:0]      o_rdata,
   output logic             o_rvalid,
   output logic             o_irq,
   inout  wire  [WIDTH-1:0] io_gpio
);

   localparam logic [2:0] ADDR_OUT  = 3'd0;
   localparam logic [2:0] ADDR_DIR  = 3'd1;
   localparam logic [2:0] ADDR_IN   = 3'd2;
   localparam logic [2:0] ADDR_EDGE = 3'd3;
   localparam logic [2:0] ADDR_MASK = 3'd4;
   localparam logic [2:0] ADDR_SET  = 3'd5;
   localparam logic [2:0] ADDR_CLR  = 3'd6;

   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] dir_q;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] edge_q;
   logic [WIDTH-1:0] sync1_p0;
   logic [WIDTH-1:0] sync2_p1;
   logic [WIDTH-1:0] prev_p2;

   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] edge_nxt;
   logic [31:0]      rd_mux;

   function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
      logic [31:0] r;
      r = '0;
      r[WIDTH-1:0] = v;
      return r;
   endfunction

   assign wr_en = i_clk_en & i_sel & i_wr;
   assign rd_en = i_clk_en & i_sel & i_rd;
   assign wdata = i_wdata[WIDTH-1:0];

   // Pins are released (high-Z) wherever the direction bit selects input.
   for (genvar n = 0; n < WIDTH; n++) begin : g_pin
      assign io_gpio[n] = dir_q[n] ? out_q[n] : 1'bz;
   end

   always_comb begin
      w1c = '0;
      if (wr_en && (i_addr == ADDR_EDGE))
         w1c = wdata;
      // A freshly detected edge overrides a simultaneous clear of the same bit.
      edge_nxt = (edge_q & ~w1c) | (sync2_p1 & ~prev_p2);
   end

   always_comb begin
      rd_mux = '0;
      case (i_addr)
         ADDR_OUT:  rd_mux = zext(out_q);
         ADDR_DIR:  rd_mux = zext(dir_q);
         ADDR_IN:   rd_mux = zext(sync2_p1);
         ADDR_EDGE: rd_mux = zext(edge_q);
         ADDR_MASK: rd_mux = zext(mask_q);
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         out_q    <= OUT_RESET[WIDTH-1:0];
         dir_q    <= DIR_RESET[WIDTH-1:0];
         mask_q   <= '0;
         edge_q   <= '0;
         sync1_p0 <= '0;
         sync2_p1 <= '0;
         prev_p2  <= '0;
         o_rdata  <= '0;
         o_rvalid <= 1'b0;
      end else if (i_clk_en) begin
         // Stage p0 -> p1 -> p2: synchroniser pair, then previous-value for edge detect
         sync1_p0 <= io_gpio;
         sync2_p1 <= sync1_p0;
         prev_p2  <= sync2_p1;
         edge_q   <= edge_nxt;
         o_rvalid <= rd_en;
         if (rd_en)
            o_rdata <= rd_mux;
         if (wr_en) begin
            case (i_addr)
               ADDR_OUT:  out_q  <= wdata;
               ADDR_DIR:  dir_q  <= wdata;
               ADDR_MASK: mask_q <= wdata;
               ADDR_SET:  out_q  <= out_q | wdata;
               ADDR_CLR:  out_q  <= out_q & ~wdata;
               default:   ;
            endcase
         end
      end
   end

   assign o_irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_gpio_port.sv
// Directed self-checking bench for gpio_port: bus access, pin drive/sample,
// edge capture, interrupt, clock enable, collisions and asynchronous reset.
module tb_gpio_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic        sel;
   logic        wr;
   logic        rd;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;
   logic        irq;
   wire  [31:0] io_gpio;

   logic [31:0] tb_en;
   logic [31:0] tb_val;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < 32; i++) begin : g_drv
      assign io_gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
   end

   gpio_port #(
      .WIDTH(32),
      .OUT_RESET(32'h0),
      .DIR_RESET(32'h0)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_clk_en(clk_en),
      .i_sel(sel),
      .i_wr(wr),
      .i_rd(rd),
      .i_addr(addr),
      .i_wdata(wdata),
      .o_rdata(rdata),
      .o_rvalid(rvalid),
      .o_irq(irq),
      .io_gpio(io_gpio)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
      tick();
      sel = 1'b0; wr = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic v);
      sel = 1'b1; rd = 1'b1; addr = a;
      tick();
      sel = 1'b0; rd = 1'b0;
      d = rdata;
      v = rvalid;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic        v;
      total++;
      if (rdata !== 32'h0 || rvalid !== 1'b0 || irq !== 1'b0) begin
         $display("FAIL reset_outputs: got rdata=%h rvalid=%b irq=%b required 0/0/0", rdata, rvalid, irq);
      end else passed++;
      rst = 1'b0;
      tick();
      total++;
      if (rvalid !== 1'b0) $display("FAIL reset_idle_rvalid: got %b required 0", rvalid);
      else passed++;
      bus_read(3'd1, d, v);
      total++;
      if (d !== 32'h0 || v !== 1'b1) $display("FAIL reset_dir_read: got %h vld=%b required 00000000 vld=1", d, v);
      else passed++;
      tick();
      total++;
      if (rvalid !== 1'b0) $display("FAIL reset_rvalid_pulse: got %b required 0", rvalid);
      else passed++;
   endtask

   task automatic test_output_drive();
      logic [31:0] d;
      logic        v;
      tb_en  = 32'hFFFF_FF00;
      tb_val = 32'h1234_5600;
      bus_write(3'd1, 32'h0000_00FF);
      bus_write(3'd0, 32'h0000_00A5);
      total++;
      if (io_gpio[7:0] !== 8'hA5) $display("FAIL drive_pins: got %h required a5", io_gpio[7:0]);
      else passed++;
      bus_read(3'd0, d, v);
      total++;
      if (d !== 32'h0000_00A5 || v !== 1'b1) $display("FAIL drive_out_read: got %h required 000000a5", d);
      else passed++;
      bus_read(3'd1, d, v);
      total++;
      if (d !== 32'h0000_00FF) $display("FAIL drive_dir_read: got %h required 000000ff", d);
      else passed++;
      bus_read(3'd2, d, v);
      total++;
      if (d !== 32'h1234_56A5) $display("FAIL drive_in_readback: got %h required 123456a5", d);
      else passed++;
   endtask

   task automatic test_set_clear();
      logic [31:0] d;
      logic        v;
      bus_write(3'd5, 32'h0000_0F00);
      bus_write(3'd6, 32'h0000_0005);
      bus_read(3'd0, d, v);
      total++;
      if (d !== 32'h0000_0FA0) $display("FAIL setclr_out: got %h required 00000fa0", d);
      else passed++;
      total++;
      if (io_gpio[7:0] !== 8'hA0) $display("FAIL setclr_pins: got %h required a0", io_gpio[7:0]);
      else passed++;
      bus_read(3'd5, d, v);
      total++;
      if (d !== 32'h0) $display("FAIL setclr_set_read: got %h required 00000000", d);
      else passed++;
      bus_read(3'd7, d, v);
      total++;
      if (d !== 32'h0 || v !== 1'b1) $display("FAIL reserved_read: got %h vld=%b required 00000000 vld=1", d, v);
      else passed++;
   endtask

   task automatic test_input_sync();
      logic [31:0] d;
      logic        v;
      logic        v2;
      bus_write(3'd1, 32'h0);
      tb_en  = 32'hFFFF_FFFF;
      tb_val = 32'h0;
      ticks(4);
      bus_write(3'd3, 32'hFFFF_FFFF);
      bus_read(3'd2, d, v);
      total++;
      if (d !== 32'h0) $display("FAIL sync_baseline: got %h required 00000000", d);
      else passed++;
      tb_val = 32'h1234_5678;
      tick();
      bus_read(3'd2, d, v);
      total++;
      if (d !== 32'h0) $display("FAIL sync_early_read: got %h required 00000000", d);
      else passed++;
      bus_read(3'd2, d, v2);
      total++;
      if (d !== 32'h1234_5678) $display("FAIL sync_latency_read: got %h required 12345678", d);
      else passed++;
      total++;
      if (v !== 1'b1 || v2 !== 1'b1) $display("FAIL back_to_back_rvalid: got %b%b required 11", v, v2);
      else passed++;
      tick();
      total++;
      if (rvalid !== 1'b0) $display("FAIL rvalid_drop: got %b required 0", rvalid);
      else passed++;
   endtask

   task automatic test_edge_irq();
      logic [31:0] d;
      logic        v;
      tb_val = 32'h0;
      ticks(3);
      bus_write(3'd3, 32'hFFFF_FFFF);
      bus_write(3'd4, 32'h0000_0001);
      total++;
      if (irq !== 1'b0) $display("FAIL irq_idle: got %b required 0", irq);
      else passed++;
      tb_val = 32'h0000_0001;
      ticks(2);
      total++;
      if (irq !== 1'b0) $display("FAIL irq_too_early: got %b required 0", irq);
      else passed++;
      tick();
      total++;
      if (irq !== 1'b1) $display("FAIL irq_rise: got %b required 1", irq);
      else passed++;
      bus_read(3'd3, d, v);
      total++;
      if (d !== 32'h0000_0001) $display("FAIL edge_bit0: got %h required 00000001", d);
      else passed++;
      bus_write(3'd3, 32'h0000_0001);
      total++;
      if (irq !== 1'b0) $display("FAIL irq_clear: got %b required 0", irq);
      else passed++;
      tb_val = 32'h0000_0003;
      ticks(3);
      bus_read(3'd3, d, v);
      total++;
      if (d !== 32'h0000_0002) $display("FAIL edge_unmasked: got %h required 00000002", d);
      else passed++;
      total++;
      if (irq !== 1'b0) $display("FAIL irq_masked: got %b required 0", irq);
      else passed++;
   endtask

   task automatic test_clk_en();
      logic [31:0] d;
      logic        v;
      clk_en = 1'b0;
      bus_write(3'd0, 32'h0000_FFFF);
      clk_en = 1'b1;
      bus_read(3'd0, d, v);
      total++;
      if (d !== 32'h0000_0FA0) $display("FAIL clken_write_blocked: got %h required 00000fa0", d);
      else passed++;
      clk_en = 1'b0;
      tick();
      total++;
      if (rvalid !== 1'b1) $display("FAIL clken_rvalid_hold: got %b required 1", rvalid);
      else passed++;
      clk_en = 1'b1;
      tick();
      total++;
      if (rvalid !== 1'b0) $display("FAIL clken_rvalid_release: got %b required 0", rvalid);
      else passed++;
   endtask

   task automatic test_collision();
      logic [31:0] d;
      logic        v;
      tb_val = 32'h0000_0002;
      ticks(3);
      tb_val = 32'h0000_0003;
      ticks(2);
      bus_write(3'd3, 32'h0000_0001);
      bus_read(3'd3, d, v);
      total++;
      if (d !== 32'h0000_0003) $display("FAIL w1c_set_wins: got %h required 00000003", d);
      else passed++;
   endtask

   task automatic test_rdwr();
      logic [31:0] d;
      logic        v;
      sel = 1'b1; wr = 1'b1; rd = 1'b1; addr = 3'd4; wdata = 32'h0000_0055;
      tick();
      sel = 1'b0; wr = 1'b0; rd = 1'b0;
      total++;
      if (rdata !== 32'h0000_0001 || rvalid !== 1'b1) $display("FAIL rdwr_old_value: got %h vld=%b required 00000001 vld=1", rdata, rvalid);
      else passed++;
      bus_read(3'd4, d, v);
      total++;
      if (d !== 32'h0000_0055) $display("FAIL rdwr_new_value: got %h required 00000055", d);
      else passed++;
   endtask

   task automatic test_reset_midcycle();
      logic [31:0] d;
      logic        v;
      total++;
      if (irq !== 1'b1) $display("FAIL pre_reset_irq: got %b required 1", irq);
      else passed++;
      tb_en = 32'hFFFF_FF00;
      bus_write(3'd1, 32'h0000_00FF);
      bus_read(3'd4, d, v);
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (rdata !== 32'h0 || rvalid !== 1'b0 || irq !== 1'b0) begin
         $display("FAIL async_reset_outputs: got rdata=%h rvalid=%b irq=%b required 0/0/0", rdata, rvalid, irq);
      end else passed++;
      sel = 1'b1; wr = 1'b1; addr = 3'd0; wdata = 32'h0000_00FF;
      ticks(2);
      sel = 1'b0; wr = 1'b0;
      rst = 1'b0;
      tb_en  = 32'hFFFF_FFFF;
      tb_val = 32'hCAFE_0000;
      ticks(3);
      bus_read(3'd2, d, v);
      total++;
      if (d !== 32'hCAFE_0000) $display("FAIL reset_pins_released: got %h required cafe0000", d);
      else passed++;
      total++;
      if (rvalid !== 1'b1) $display("FAIL post_reset_rvalid: got %b required 1", rvalid);
      else passed++;
      bus_read(3'd1, d, v);
      total++;
      if (d !== 32'h0) $display("FAIL post_reset_dir: got %h required 00000000", d);
      else passed++;
      bus_read(3'd0, d, v);
      total++;
      if (d !== 32'h0) $display("FAIL reset_blocks_write: got %h required 00000000", d);
      else passed++;
   endtask

   initial begin
      rst    = 1'b1;
      clk_en = 1'b1;
      sel    = 1'b0;
      wr     = 1'b0;
      rd     = 1'b0;
      addr   = 3'd0;
      wdata  = 32'h0;
      tb_en  = 32'h0;
      tb_val = 32'h0;
      ticks(3);
      test_reset();
      test_output_drive();
      test_set_clear();
      test_input_sync();
      test_edge_irq();
      test_clk_en();
      test_collision();
      test_rdwr();
      test_reset_midcycle();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
